// File: rtl/pmem_pkg.sv
// Shared types and sizing for the physical-memory burst adapter.
package pmem_pkg;

  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } pmem_state_t;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;

endpackage

// File: rtl/pmem_burst_adapter.sv
// Turns one 256-bit cache-line request into a 4 x 64-bit memory burst and back.
// Define PMEM_ADAPTER_WRITE_EN for the read/write (data-cache) build; default is read-only.
module pmem_burst_adapter #(
  parameter int BEATS  = pmem_pkg::BEATS,
  parameter int BEAT_W = pmem_pkg::BEAT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               address_i,
  input  logic [BEATS*BEAT_W-1:0]   line_i,
  input  logic                      read_i,
  input  logic                      write_i,
  output logic [BEATS*BEAT_W-1:0]   line_o,
  output logic                      resp_o,
  input  logic [BEAT_W-1:0]         burst_i,
  output logic [BEAT_W-1:0]         burst_o,
  output logic [31:0]               address_o,
  output logic                      read_o,
  output logic                      write_o,
  input  logic                      resp_i
);
  import pmem_pkg::*;

  localparam int LW    = BEATS * BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LW / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  pmem_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [LW-1:0]      line_q, line_d;
  logic               wr_req;

`ifdef PMEM_ADAPTER_WRITE_EN
  logic [LW-1:0]      buf_q, buf_d;

  assign wr_req  = write_i;
  assign write_o = (state_q == WRITE);
  assign burst_o = write_o ? buf_q[cnt_q*BEAT_W +: BEAT_W] : '0;

  // Line is captured on acceptance so later line_i changes cannot leak into the burst.
  always_comb begin
    buf_d = buf_q;
    if (state_q == IDLE && write_i) buf_d = line_i;
  end

  always_ff @(posedge clk) begin
    if (rst) buf_q <= '0;
    else     buf_q <= buf_d;
  end
`else
  logic unused_wr;

  assign wr_req    = 1'b0;
  assign write_o   = 1'b0;
  assign burst_o   = '0;
  assign unused_wr = ^{write_i, line_i};
`endif

  assign read_o    = (state_q == READ);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        // Write-back wins so a dirty victim leaves before its refill arrives.
        if (wr_req) begin
          addr_d  = {address_i[31:OFF_W], {OFF_W{1'b0}}};
          cnt_d   = '0;
          state_d = WRITE;
        end else if (read_i) begin
          addr_d  = {address_i[31:OFF_W], {OFF_W{1'b0}}};
          cnt_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (resp_i) begin
          line_d[cnt_q*BEAT_W +: BEAT_W] = burst_i;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
`ifdef PMEM_ADAPTER_WRITE_EN
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Scoreboard bench for pmem_burst_adapter: stimulus pushes expectations, a negedge monitor checks them.
module tb_pmem_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic         read_i, write_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_i, burst_o;
  logic [31:0]  address_o;
  logic         read_o, write_o, resp_i;

  pmem_burst_adapter dut (
    .clk(clk), .rst(rst), .address_i(address_i), .line_i(line_i),
    .read_i(read_i), .write_i(write_i), .line_o(line_o), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_rd;
    logic [255:0] line;
    logic [31:0]  addr;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] beat_q[$];
  int checks = 0, failures = 0, resp_cnt = 0, rd_cyc = 0, exp_resps = 0;

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares write beats and completion responses against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (read_o) rd_cyc++;
      if (write_o && resp_i) begin
        if (beat_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_wbeat: got %h expected none", burst_o);
        end else chk("wbeat", burst_o, beat_q.pop_front());
      end
      if (resp_o) begin
        resp_cnt++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_resp: got resp_o=1 expected 0");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_addr", address_o, e.addr);
          if (e.is_rd) chk("resp_line", line_o, e.line);
        end
      end
    end
  end

  // Drives beats per pattern bit until four are sent; ends in the resp_o cycle.
  task automatic run_beats(input bit is_rd, input logic [255:0] line, input logic [15:0] pat,
                           input string tag);
    int n = 0, cyc = 0, rd0;
    rd0 = rd_cyc;
    for (int i = 0; i < 16 && n < 4; i++) begin
      resp_i  = pat[i];
      burst_i = (is_rd && pat[i]) ? line[n*64 +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
      if (pat[i]) n++;
      cyc++;
      step();
    end
    resp_i  = 1'b0;
    burst_i = '0;
    chk({tag, "_resp_o"}, resp_o, 1);
    if (is_rd) chk({tag, "_rd_cycles"}, rd_cyc - rd0, cyc);
  endtask

  // Stray strobe in the DONE cycle, then the cache drops its request.
  task automatic close_txn(input string tag);
    resp_i  = 1'b1;
    burst_i = 64'hDEAD_DEAD_DEAD_DEAD;
    step();
    resp_i  = 1'b0;
    read_i  = 1'b0;
    write_i = 1'b0;
    chk({tag, "_resp_drop"}, resp_o, 0);
  endtask

  task automatic read_txn(input logic [31:0] addr, input logic [255:0] line,
                          input logic [15:0] pat, input string tag);
    exp_t e;
    int r0;
    e.is_rd = 1'b1; e.line = line; e.addr = {addr[31:5], 5'b0};
    exp_q.push_back(e);
    exp_resps++;
    r0 = resp_cnt;
    read_i = 1'b1; address_i = addr;
    step();
    address_i = 32'hFFFF_FFFF;
    chk({tag, "_read_o"}, read_o, 1);
    chk({tag, "_addr_o"}, address_o, {addr[31:5], 5'b0});
    run_beats(1'b1, line, pat, tag);
    close_txn(tag);
    chk({tag, "_line_hold"}, line_o, line);
    step();
    chk({tag, "_resp_once"}, resp_cnt - r0, 1);
  endtask

  initial begin
    int r0;
    rst = 1'b1; address_i = '0; line_i = '0; read_i = 0; write_i = 0; resp_i = 0; burst_i = '0;
    step(); step();
    chk("rst_resp_o", resp_o, 0);
    chk("rst_read_o", read_o, 0);
    chk("rst_write_o", write_o, 0);
    chk("rst_addr_o", address_o, 0);
    chk("rst_burst_o", burst_o, 0);
    chk("rst_line_o", line_o, 0);
    rst = 1'b0;
    resp_i = 1'b1;  // ignored in IDLE
    step();
    resp_i = 1'b0;
    chk("idle_line_o", line_o, 0);

    read_txn(32'h0000_125C, {B4, B3, B2, B1}, 16'h000F, "rd_b2b");
    read_txn(32'h8000_0FFF, {B1, B2, B3, B4}, 16'h0059, "rd_gap");

`ifdef PMEM_ADAPTER_WRITE_EN
    begin
      exp_t e;
      logic [255:0] wl;
      wl = {64'd3, 64'd2, 64'd1, 64'd0};
      e.is_rd = 0; e.line = '0; e.addr = 32'h0000_2000;
      exp_q.push_back(e); exp_resps++;
      for (int k = 0; k < 4; k++) beat_q.push_back(64'(k));
      r0 = resp_cnt;
      write_i = 1'b1; line_i = wl; address_i = 32'h0000_2014;
      step();
      line_i = ~wl;
      chk("wr_write_o", write_o, 1);
      chk("wr_beat0", burst_o, 0);
      run_beats(1'b0, '0, 16'h002B, "wr");
      chk("wr_write_done", write_o, 0);
      close_txn("wr");
      step();
      chk("wr_resp_once", resp_cnt - r0, 1);

      // Both requests: write-back first, then the held refill.
      e.is_rd = 0; e.line = '0; e.addr = 32'h0000_3000;
      exp_q.push_back(e); exp_resps++;
      for (int k = 0; k < 4; k++) beat_q.push_back(64'hA0 + 64'(k));
      e.is_rd = 1; e.line = {B3, B1, B4, B2}; e.addr = 32'h0000_3000;
      exp_q.push_back(e); exp_resps++;
      write_i = 1'b1; read_i = 1'b1; address_i = 32'h0000_3000;
      line_i = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
      step();
      chk("both_write_first", write_o, 1);
      chk("both_no_read", read_o, 0);
      run_beats(1'b0, '0, 16'h000F, "both_wr");
      step();
      write_i = 1'b0;
      chk("both_idle", read_o, 0);
      step();
      chk("both_read_o", read_o, 1);
      run_beats(1'b1, {B3, B1, B4, B2}, 16'h000F, "both_rd");
      close_txn("both");
      chk("both_line_hold", line_o, {B3, B1, B4, B2});
    end
`else
    r0 = resp_cnt;
    write_i = 1'b1; line_i = {4{B3}}; address_i = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      resp_i = k[0];
      step();
      chk("ro_write_o", write_o, 0);
      chk("ro_burst_o", burst_o, 0);
      chk("ro_read_o", read_o, 0);
    end
    resp_i = 1'b0; write_i = 1'b0;
    step();
    chk("ro_no_resp", resp_cnt - r0, 0);
    // Write ignored, so a combined request behaves as a plain refill.
    write_i = 1'b1;
    read_txn(32'h0000_3010, {B3, B1, B4, B2}, 16'h000F, "ro_both");
    write_i = 1'b0;
`endif

    // Reset after beat 2 abandons the burst.
    r0 = resp_cnt;
    read_i = 1'b1; address_i = 32'h0000_4000;
    step();
    run_beats_partial: for (int k = 0; k < 3; k++) begin
      resp_i = 1'b1; burst_i = B4;
      step();
    end
    resp_i = 1'b0;
    rst = 1'b1; read_i = 1'b0;
    step();
    chk("mrst_read_o", read_o, 0);
    chk("mrst_resp_o", resp_o, 0);
    chk("mrst_cnt", dut.cnt_q, 0);
    chk("mrst_line_o", line_o, 0);
    chk("mrst_addr_o", address_o, 0);
    rst = 1'b0;
    step();
    chk("mrst_no_resp", resp_cnt - r0, 0);
    read_txn(32'h0000_4020, {B2, B2, B3, B1}, 16'h000F, "post_rst");

    repeat (3) step();
    chk("exp_q_empty", exp_q.size(), 0);
    chk("beat_q_empty", beat_q.size(), 0);
    chk("total_resps", resp_cnt, exp_resps);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmem_burst_adapter.md
# pmem_burst_adapter

Sits between the cache datapaths and physical memory. Converts a single 256-bit cache-line request (read refill or dirty write-back) into a four-beat, 64-bit-per-beat burst on the physical-memory bus, and reassembles returned beats into a line. Downstream of the instruction and data cache datapaths: it consumes their `pmem_address` and line data, and produces their `pmem_rdata` and response.

## Interface
Parameters:
- `BEATS`, 4: beats per line; fixed, with `BEATS` × `BEAT_W` = 256.
- `BEAT_W`, 64: bits per memory beat.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `address_i`  in  32  line address from the cache; bits [4:0] are ignored
- `line_i`  in  256  write-back line
- `read_i`  in  1  line refill request; held until `resp_o`
- `write_i`  in  1  line write-back request; held until `resp_o`
- `line_o`  out  256  assembled refill line
- `resp_o`  out  1  one-cycle completion pulse
- `burst_i`  in  64  read beat from memory
- `burst_o`  out  64  write beat to memory
- `address_o`  out  32  latched line address, {addr[31:5], 5'b0}
- `read_o`  out  1  memory read request
- `write_o`  out  1  memory write request
- `resp_i`  in  1  memory beat strobe; one beat is transferred per high cycle

## Operation
States: `IDLE`, `READ`, `WRITE`, `DONE`. Beat counter `cnt` is 2 bits.
- `IDLE`:
  - If `write_i` is high: latch the address and `line_i`, set `cnt`=0, go to `WRITE`.
  - Else if `read_i` is high: latch the address, set `cnt`=0, go to `READ`.
  - `write_i` has priority when both are high, so a dirty write-back precedes the refill.
  - `resp_i` is ignored in this state.
- `READ`:
  - `read_o`=1.
  - On each cycle with `resp_i` high: `line_o[64*cnt +: 64]` ← `burst_i`, then `cnt`++.
  - On the beat where `cnt`==3, go to `DONE`.
  - Gaps (cycles with `resp_i` low) hold all state.
- `WRITE`:
  - `write_o`=1 and `burst_o` = `line_buf[64*cnt +: 64]`.
  - Advance `cnt` on `resp_i`; go to `DONE` after beat 3.
- `DONE`:
  - `resp_o`=1 for exactly one cycle, then go unconditionally to `IDLE`.
  - `read_o`/`write_o` are 0 in this state.
  - `line_o` holds its value until the next read begins.
  - Extra `resp_i` pulses are ignored.
- Changes to `address_i` or `line_i` after the request is latched have no effect on the transaction in flight.
- Counter wrap: `cnt` 3→0 coincides with leaving `READ`/`WRITE`; it never wraps inside a transaction.

## Timing
- Request sampled at edge t. `read_o`/`write_o` and `address_o` are valid from cycle t+1.
- With back-to-back `resp_i` starting in cycle t+1, beats land at edges t+1..t+4. `resp_o` is high in cycle t+5, so the minimum latency is 5 cycles.
- The cache drops its request at the edge that ends the `resp_o` cycle. Because `DONE` is followed by `IDLE`, a held request is never re-accepted.
- `line_o` is valid during the `resp_o` cycle.
- Reset mid-transaction:
  - At the next edge, the state returns to `IDLE`, `cnt`=0, and all outputs return to reset values.
  - The partial burst is abandoned.
- Reset values:
  - `resp_o`, `read_o`, `write_o`: 0
  - `address_o`, `burst_o`, `line_o`: 0
- All outputs are registered or decoded from state only; there is no combinational path from `resp_i` to `resp_o`.

## Configuration
- `PMEM_ADAPTER_WRITE_EN`:
  - **Defined:** full read/write adapter, used for the data-cache path.
  - **Undefined:** `WRITE` state, `line_buf` and `burst_o` drive logic are removed. `write_o` and `burst_o` are tied to 0 and `write_i`/`line_i` are ignored. This is the read-only variant for the instruction-cache path.

## Structure
- Shared package `pmem_pkg`:
  - `BEAT_W`, `BEATS`, `LINE_W`=256
  - `pmem_state_t` enum {`IDLE`, `READ`, `WRITE`, `DONE`}
  - `line_t`, `beat_t` typedefs
- Single module; no sub-module. The counter and shift logic are too small to split out.

## Test plan
- Read, memory answers beats 0x1111…, 0x2222…, 0x3333…, 0x4444… back-to-back → `read_o` high for 4 cycles, `address_o`=0x0000_1240 for `address_i`=0x0000_125C, `resp_o` at t+5, `line_o`={0x4444…,0x3333…,0x2222…,0x1111…}.
- Read with `resp_i` pattern 1,0,0,1,1,0,1 → 4 beats captured in order, `resp_o` exactly once, one cycle after the last beat.
- Write of line with word k = k → `burst_o` sequence is beats 0,1,2,3 on successive `resp_i`; `write_o` drops in `DONE`; `resp_o` pulses once. Without the macro: `write_o` stays 0 and `resp_o` never fires.
- `read_i` and `write_i` both high → write burst completes, `resp_o`; the held `read_i` is then accepted from `IDLE` and a second burst follows.
- `rst` asserted after beat 2 of a read → next cycle `read_o`=0, `resp_o`=0, `cnt`=0. A fresh read then completes normally with all 4 beats.
